// File: rtl/fp_add_issue.sv
// Issue stage and in-order result capture for the fp_add core, with sticky FCSR-style flags.
// Define FP_ADD_ISSUE_TAG_EN to carry a TAG_W-bit user tag from in_tag through to res_tag.
module fp_add_issue #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int W     = 32
`ifdef FP_ADD_ISSUE_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2:0]       in_rm,
  output logic [W-1:0]     add_in1,
  output logic [W-1:0]     add_in2,
  output logic [2:0]       add_round_m,
  output logic             add_act,
  input  logic [W-1:0]     add_out,
  input  logic             add_ov,
  input  logic             add_un,
  input  logic             add_inv,
  input  logic             add_inexact,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [3:0]       res_flags,
  output logic [3:0]       fflags,
  input  logic             fflags_clr,
`ifdef FP_ADD_ISSUE_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] res_tag,
`endif
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(LAT + DEPTH + 2) + 1;

  logic [LAT:0]    vpipe;
  logic            issue;
  logic            push;
  logic            pop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   inflight;
  logic [SW-1:0]   occupancy;
  logic [3:0]      push_flags;
  logic [W-1:0]    data_mem [DEPTH];
  logic [3:0]      flag_mem [DEPTH];

  assign issue      = in_valid && in_ready;
  assign push       = vpipe[LAT];
  assign pop        = res_valid && res_ready;
  assign push_flags = {add_inv, add_ov, add_un, add_inexact};

  // Every in-flight op already owns a FIFO slot, so the FIFO cannot overflow.
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= LAT; k++) begin
      inflight = inflight + SW'(vpipe[k]);
    end
  end

  assign occupancy = inflight + SW'(count) - SW'(pop);
  assign in_ready  = occupancy < SW'(DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[LAT-1:0], issue};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_in1     <= '0;
      add_in2     <= '0;
      add_round_m <= '0;
    end else if (issue) begin
      add_in1     <= in_a;
      add_in2     <= in_b;
      add_round_m <= in_rm;
    end
  end

  assign add_act = vpipe[0];

  // NOTE: FIFO storage has no reset; count gates res_valid, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= add_out;
      flag_mem[wr_ptr] <= push_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign res_valid = (count != '0);
  assign res_data  = data_mem[rd_ptr];
  assign res_flags = flag_mem[rd_ptr];
  assign busy      = (|vpipe) || (count != '0);

  // A clear coinciding with a push keeps only the newly pushed flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags <= '0;
    end else if (push) begin
      fflags <= (fflags_clr ? 4'b0000 : fflags) | push_flags;
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

`ifdef FP_ADD_ISSUE_TAG_EN
  logic [TAG_W-1:0] tpipe   [LAT+1];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  // Tags travel beside vpipe; a slot's tag is only meaningful while its vpipe bit is set.
  always_ff @(posedge clk) begin
    if (issue) tpipe[0] <= in_tag;
    for (int k = 1; k <= LAT; k++) begin
      tpipe[k] <= tpipe[k-1];
    end
    if (push) tag_mem[wr_ptr] <= tpipe[LAT];
  end

  assign res_tag = tag_mem[rd_ptr];
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == CW'(DEPTH))))
    else $error("fp_add_issue: push into full result FIFO");
`endif

endmodule

// File: tb/tb_fp_add_issue.sv
// Scoreboard bench for fp_add_issue: a table-driven adder model feeds the DUT,
// expected results are queued at handshake and popped by a monitor at each result pop.
module tb_fp_add_issue;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int NV    = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_rm = '0;
  logic [W-1:0]  add_in1;
  logic [W-1:0]  add_in2;
  logic [2:0]    add_round_m;
  logic          add_act;
  logic [W-1:0]  add_out;
  logic          add_ov, add_un, add_inv, add_inexact;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [W-1:0]  res_data;
  logic [3:0]    res_flags;
  logic [3:0]    fflags;
  logic          fflags_clr = 1'b0;
  logic          busy;
`ifdef FP_ADD_ISSUE_TAG_EN
  logic [3:0]    in_tag = '0;
  logic [3:0]    res_tag;
`endif

  fp_add_issue #(.LAT(LAT), .DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rm(in_rm),
    .add_in1(add_in1), .add_in2(add_in2), .add_round_m(add_round_m), .add_act(add_act),
    .add_out(add_out), .add_ov(add_ov), .add_un(add_un), .add_inv(add_inv),
    .add_inexact(add_inexact),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .fflags(fflags), .fflags_clr(fflags_clr),
`ifdef FP_ADD_ISSUE_TAG_EN
    .in_tag(in_tag), .res_tag(res_tag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors: operands, rounding mode, hand-computed result and flags {inv,ov,un,inexact}.
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [2:0]  vm [NV];
  logic [31:0] vr [NV];
  logic [3:0]  vf [NV];

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] m, input logic [31:0] r, input logic [3:0] f);
    va[i] = a; vb[i] = b; vm[i] = m; vr[i] = r; vf[i] = f;
  endtask

  task automatic lookup(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f);
    r = a ^ b;
    f = 4'b0000;
    for (int i = NV - 1; i >= 0; i--) begin
      if (va[i] == a && vb[i] == b) begin
        r = vr[i];
        f = vf[i];
      end
    end
  endtask

  // Adder model: LAT-cycle pipeline from add_in* to add_out.
  logic [31:0] m_res [LAT];
  logic [3:0]  m_flg [LAT];
  logic [31:0] m_r;
  logic [3:0]  m_f;
  always @(posedge clk) begin
    lookup(add_in1, add_in2, m_r, m_f);
    m_res[0] <= m_r;
    m_flg[0] <= m_f;
    for (int k = 1; k < LAT; k++) begin
      m_res[k] <= m_res[k-1];
      m_flg[k] <= m_flg[k-1];
    end
  end
  assign add_out = m_res[LAT-1];
  assign {add_inv, add_ov, add_un, add_inexact} = m_flg[LAT-1];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
  } iss_t;

  exp_t exp_q [$];
  iss_t iss_q [$];
  int   hs_q  [$];
  int   pop_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: adder-side issue order and result-side scoreboard.
  exp_t e_mon;
  iss_t i_mon;
  always @(negedge clk) begin
    if (rst) begin
      if (add_act) begin
        if (iss_q.size() == 0) begin
          check("act_unexpected", 32'd1, 32'd0);
        end else begin
          i_mon = iss_q.pop_front();
          check("add_in1", add_in1, i_mon.a);
          check("add_in2", add_in2, i_mon.b);
          check("add_round_m", 32'(add_round_m), 32'(i_mon.rm));
        end
      end
      if (res_valid && res_ready) begin
        pop_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("res_unexpected", 32'd1, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check("res_data", res_data, e_mon.data);
          check("res_flags", 32'(res_flags), 32'(e_mon.flags));
`ifdef FP_ADD_ISSUE_TAG_EN
          check("res_tag", 32'(res_tag), 32'(e_mon.tag));
`endif
        end
      end
    end
  end

  task automatic accept(input int idx);
    exp_t e;
    iss_t s;
    e.data = vr[idx]; e.flags = vf[idx]; e.tag = 4'(idx);
    s.a = va[idx]; s.b = vb[idx]; s.rm = vm[idx];
    exp_q.push_back(e);
    iss_q.push_back(s);
    hs_q.push_back(cyc);
  endtask

  // Holds in_valid high and walks table entries first..first+n-1, one per handshake.
  task automatic stream(input int first, input int n, input int budget,
                        output int acc, output int stalls);
    acc = 0;
    stalls = 0;
    for (int c = 0; c < budget && acc < n; c++) begin
      in_valid = 1'b1;
      in_a = va[first+acc];
      in_b = vb[first+acc];
      in_rm = vm[first+acc];
`ifdef FP_ADD_ISSUE_TAG_EN
      in_tag = 4'(first + acc);
`endif
      @(negedge clk);
      if (in_ready) begin
        accept(first + acc);
        acc++;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    if (acc == n) in_valid = 1'b0;
  endtask

  task automatic issue_one(input int idx);
    int acc, st;
    stream(idx, 1, 50, acc, st);
    check("issue_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", 32'(c < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, st;

    set_vec( 0, 32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000);
    set_vec( 1, 32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 4'b1000);
    set_vec( 2, 32'h3F800000, 32'h30800000, 3'd0, 32'h3F800000, 4'b0001);
    set_vec( 3, 32'h3F800000, 32'h40000000, 3'd1, 32'h40400000, 4'b0000);
    set_vec( 4, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, 4'b0101);
    set_vec( 5, 32'h40000000, 32'h40000000, 3'd1, 32'h40800000, 4'b0000);
    set_vec( 6, 32'h3F800000, 32'h40400000, 3'd2, 32'h40800000, 4'b0000);
    set_vec( 7, 32'h40000000, 32'h40400000, 3'd3, 32'h40A00000, 4'b0000);
    set_vec( 8, 32'h40400000, 32'h40400000, 3'd4, 32'h40C00000, 4'b0000);
    set_vec( 9, 32'h40400000, 32'h40800000, 3'd0, 32'h40E00000, 4'b0000);
    set_vec(10, 32'h40800000, 32'h40800000, 3'd0, 32'h41000000, 4'b0000);
    set_vec(11, 32'h3F000000, 32'h3F800000, 3'd0, 32'h3FC00000, 4'b0000);
    set_vec(12, 32'h3F000000, 32'h3F000000, 3'd1, 32'h3F800000, 4'b0000);
    set_vec(13, 32'h3F800000, 32'h3F800000, 3'd2, 32'h40000000, 4'b0000);
    set_vec(14, 32'h40000000, 32'h40800000, 3'd3, 32'h40C00000, 4'b0000);
    set_vec(15, 32'h3F800000, 32'h40800000, 3'd4, 32'h40A00000, 4'b0000);
    set_vec(16, 32'h40800000, 32'h3F800000, 3'd0, 32'h40A00000, 4'b0000);
    set_vec(17, 32'h40000000, 32'h3F800000, 3'd1, 32'h40400000, 4'b0000);
    set_vec(18, 32'h40800000, 32'h40000000, 3'd2, 32'h40C00000, 4'b0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_act", 32'(add_act), 32'd0);
    check("rst_fflags", 32'(fflags), 32'd0);
    check("rst_add_in1", add_in1, 32'd0);
    check("rst_add_round_m", 32'(add_round_m), 32'd0);
    rst = 1'b1;
    next_cycle();

    // Basic result with cycle-exact timing
    issue_one(0);
    @(negedge clk); check("basic_act_t1", 32'(add_act), 32'd1);
    @(negedge clk); check("basic_act_t2", 32'(add_act), 32'd0);
                    check("basic_valid_t2", 32'(res_valid), 32'd0);
    @(negedge clk); check("basic_valid_t3", 32'(res_valid), 32'd0);
    @(negedge clk); check("basic_valid_t4", 32'(res_valid), 32'd1);
    drain();
    check("basic_fflags", 32'(fflags), 32'h0);

    // Invalid operation and clear
    issue_one(1);
    drain();
    check("inv_fflags", 32'(fflags), 32'h8);
    fflags_clr = 1'b1;
    next_cycle();
    fflags_clr = 1'b0;
    @(negedge clk); check("clr_fflags", 32'(fflags), 32'h0);
    next_cycle();

    // Inexact, stickiness, clear coinciding with a push
    issue_one(2);
    drain();
    check("inexact_fflags", 32'(fflags), 32'h1);
    issue_one(0);
    drain();
    check("sticky_fflags", 32'(fflags), 32'h1);
    issue_one(1);
    drain();
    check("accum_fflags", 32'(fflags), 32'h9);
    issue_one(2);
    next_cycle();
    next_cycle();
    fflags_clr = 1'b1;
    next_cycle();
    fflags_clr = 1'b0;
    @(negedge clk); check("clr_with_push", 32'(fflags), 32'h1);
    drain();

    // Overflow raises ov and inexact; leave fflags set for the reset test
    issue_one(4);
    drain();
    check("ovf_fflags", 32'(fflags), 32'h5);

    // Backpressure: only DEPTH ops accepted while the consumer stalls
    res_ready = 1'b0;
    stream(5, 6, 10, acc, st);
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    res_ready = 1'b1;
    #1;
    check("bp_pop_frees_credit", 32'(in_ready), 32'd1);
    stream(5 + acc, 6 - acc, 50, acc2, st);
    check("bp_rest_accepted", 32'(acc2), 32'd2);
    drain();

    // Throughput: 8 back-to-back ops, each result 4 cycles after its handshake
    hs_q.delete();
    pop_q.delete();
    stream(11, 8, 50, acc, st);
    check("tp_accepted", 32'(acc), 32'd8);
    check("tp_stalls", 32'(st), 32'd0);
    drain();
    check("tp_pop_count", 32'(pop_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_q.size() && i < hs_q.size()) begin
        check("tp_latency", 32'(pop_q[i] - hs_q[i]), 32'd4);
        check("tp_issue_rate", 32'(hs_q[i] - hs_q[0]), 32'(i));
      end
    end

    // Reset mid-flight drops everything in the pipe
    check("pre_rst_fflags", 32'(fflags), 32'h5);
    stream(1, 3, 20, acc, st);
    check("mid_accepted", 32'(acc), 32'd3);
    rst = 1'b0;
    exp_q.delete();
    iss_q.delete();
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fflags", 32'(fflags), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) next_cycle();
    @(negedge clk);
    check("post_rst_no_stale", 32'(res_valid), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    next_cycle();
    hs_q.delete();
    pop_q.delete();
    issue_one(0);
    drain();
    check("post_rst_pops", 32'(pop_q.size()), 32'd1);
    if (pop_q.size() == 1 && hs_q.size() == 1)
      check("post_rst_latency", 32'(pop_q[0] - hs_q[0]), 32'd4);

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_iss_empty", 32'(iss_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
